// File: rtl/lc3_control_fsm.sv
// LC-3 control sequencer: one micro-state per clock, Moore-decoded datapath controls.
// Optional build macro PAUSE_IR_EN inserts a two-state pause after each instruction fetch.
module lc3_control_fsm #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ALUK,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       MIO_EN,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    typedef enum logic [4:0] {
        StHalted, St18, St33, St35, St32,
        St01, St05, St09, St00, St22, St12,
        St04, St21, St06, St07, St25, St27, St23, St16,
        StPause1, StPause2
`ifdef PAUSE_IR_EN
        , StPauseIr1, StPauseIr2
`endif
    } state_t;

    // Last count value of a memory strobe; counter runs 0..MEM_WAIT-1.
    localparam logic [2:0] WaitLast = 3'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic       wait_done;

    assign wait_done = (wait_q == WaitLast);

    // State register and memory wait counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StHalted;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state, wait-counter and datapath control decode.
    always_comb begin
        state_d    = state_q;
        wait_d     = 3'd0;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'd0;
        ADDR2MUX   = 2'd0;
        ADDR1MUX   = 1'b0;
        ALUK       = 2'd0;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        MIO_EN     = 1'b0;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        // SRAM stays selected whenever the machine is running.
        Mem_CE     = (state_q == StHalted);
        Mem_UB     = (state_q == StHalted);
        Mem_LB     = (state_q == StHalted);

        unique case (state_q)
            StHalted: begin
                if (Run) state_d = St18;
            end
            St18: begin
                GatePC  = 1'b1;
                LD_MAR  = 1'b1;
                PCMUX   = 2'd2;
                LD_PC   = 1'b1;
                state_d = St33;
            end
            St33, St25: begin
                Mem_OE = 1'b0;
                LD_MDR = 1'b1;
                MIO_EN = 1'b1;
                if (wait_done) begin
                    state_d = (state_q == St33) ? St35 : St27;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            St35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
`ifdef PAUSE_IR_EN
                state_d = StPauseIr1;
`else
                state_d = St32;
`endif
            end
            St32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    4'b0001: state_d = St01;
                    4'b0101: state_d = St05;
                    4'b1001: state_d = St09;
                    4'b0000: state_d = St00;
                    4'b1100: state_d = St12;
                    4'b0100: state_d = St04;
                    4'b0110: state_d = St06;
                    4'b0111: state_d = St07;
                    4'b1101: state_d = StPause1;
                    default: state_d = St18;
                endcase
            end
            St01, St05, St09: begin
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                SR1MUX  = 1'b1;
                SR2MUX  = ~IR_5;
                ALUK    = (state_q == St01) ? 2'd0 : (state_q == St05) ? 2'd1 : 2'd2;
                state_d = St18;
            end
            St00: begin
                state_d = BEN ? St22 : St18;
            end
            St22: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = 2'd1;
                PCMUX    = 2'd1;
                LD_PC    = 1'b1;
                state_d  = St18;
            end
            St12: begin
                SR1MUX   = 1'b1;
                ADDR2MUX = 2'd3;
                PCMUX    = 2'd1;
                LD_PC    = 1'b1;
                state_d  = St18;
            end
            St04: begin
                GatePC  = 1'b1;
                DRMUX   = 1'b1;
                LD_REG  = 1'b1;
                state_d = St21;
            end
            St21: begin
                // JSR uses PC+off11; JSRR jumps to BaseR.
                if (IR_11) begin
                    ADDR1MUX = 1'b1;
                    ADDR2MUX = 2'd0;
                end else begin
                    SR1MUX   = 1'b1;
                    ADDR2MUX = 2'd3;
                end
                PCMUX   = 2'd1;
                LD_PC   = 1'b1;
                state_d = St18;
            end
            St06, St07: begin
                SR1MUX     = 1'b1;
                ADDR2MUX   = 2'd2;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_d    = (state_q == St06) ? St25 : St23;
            end
            St27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = St18;
            end
            St23: begin
                ALUK    = 2'd3;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                state_d = St16;
            end
            St16: begin
                Mem_WE = 1'b0;
                if (wait_done) state_d = St18;
                else wait_d = wait_q + 3'd1;
            end
            StPause1: begin
                LD_LED = 1'b1;
                if (Continue) state_d = StPause2;
            end
            StPause2: begin
                if (!Continue) state_d = St18;
            end
`ifdef PAUSE_IR_EN
            StPauseIr1: begin
                LD_LED = 1'b1;
                if (Continue) state_d = StPauseIr2;
            end
            StPauseIr2: begin
                if (!Continue) state_d = St32;
            end
`endif
            default: state_d = StHalted;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm (default build, MEM_WAIT = 2).
module tb_lc3_control_fsm;

    logic       Clk, Reset_n, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN;
    logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

    int checks = 0;
    int failures = 0;

    typedef enum {HALTED, T18, T33, T35, T32, T01, T05, T09, T00, T22, T12,
                  T04, T21, T06, T07, T25, T27, T23, T16, P1, P2} tst_t;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux;
        logic       addr1mux;
        logic [1:0] aluk;
        logic       drmux, sr1mux, sr2mux, mio_en;
        logic       mem_ce, mem_ub, mem_lb, mem_oe, mem_we;
    } ctl_t;

    ctl_t obs;
    assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ADDR1MUX, ALUK,
                  DRMUX, SR1MUX, SR2MUX, MIO_EN, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};

    lc3_control_fsm #(.MEM_WAIT(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
        .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ADDR1MUX(ADDR1MUX), .ALUK(ALUK),
        .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .MIO_EN(MIO_EN),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected control word for each micro-state, written from the state descriptions.
    function automatic ctl_t exp_ctl(tst_t s, logic ir5, logic ir11);
        ctl_t c = '0;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        c.mem_ce = (s == HALTED);
        c.mem_ub = (s == HALTED);
        c.mem_lb = (s == HALTED);
        case (s)
            T18: begin c.gate_pc = 1; c.ld_mar = 1; c.pcmux = 2; c.ld_pc = 1; end
            T33, T25: begin c.mem_oe = 0; c.ld_mdr = 1; c.mio_en = 1; end
            T35: begin c.gate_mdr = 1; c.ld_ir = 1; end
            T32: c.ld_ben = 1;
            T01, T05, T09: begin
                c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.sr1mux = 1; c.sr2mux = ~ir5;
                c.aluk = (s == T01) ? 2'd0 : (s == T05) ? 2'd1 : 2'd2;
            end
            T22: begin c.addr1mux = 1; c.addr2mux = 1; c.pcmux = 1; c.ld_pc = 1; end
            T12: begin c.sr1mux = 1; c.addr2mux = 3; c.pcmux = 1; c.ld_pc = 1; end
            T04: begin c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; end
            T21: begin
                if (ir11) begin c.addr1mux = 1; c.addr2mux = 0; end
                else begin c.sr1mux = 1; c.addr2mux = 3; end
                c.pcmux = 1; c.ld_pc = 1;
            end
            T06, T07: begin c.sr1mux = 1; c.addr2mux = 2; c.gate_marmux = 1; c.ld_mar = 1; end
            T27: begin c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
            T23: begin c.aluk = 3; c.gate_alu = 1; c.ld_mdr = 1; end
            T16: c.mem_we = 0;
            P1: c.ld_led = 1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Run = 0; Continue = 0; Opcode = 4'h0; IR_5 = 0; IR_11 = 0; BEN = 0;
        step();
        checks++;
        if (obs !== exp_ctl(HALTED, IR_5, IR_11)) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs, exp_ctl(HALTED, IR_5, IR_11));
        end
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== exp_ctl(HALTED, IR_5, IR_11)) begin
                failures++;
                $display("FAIL halted_idle[%0d] got=%h exp=%h", i, obs,
                         exp_ctl(HALTED, IR_5, IR_11));
            end
        end
    endtask

    task automatic test_start();
        Run = 1'b1;
        step();
        Run = 1'b0;
        checks++;
        if (obs !== exp_ctl(T18, IR_5, IR_11)) begin
            failures++;
            $display("FAIL start_s18 got=%h exp=%h", obs, exp_ctl(T18, IR_5, IR_11));
        end
    endtask

    task automatic test_add();
        tst_t seq [6] = '{T33, T33, T35, T32, T01, T18};
        Opcode = 4'b0001; IR_5 = 1'b1;
        foreach (seq[i]) begin
            step();
            checks++;
            if (obs !== exp_ctl(seq[i], IR_5, IR_11)) begin
                failures++;
                $display("FAIL add[%0d] got=%h exp=%h", i, obs, exp_ctl(seq[i], IR_5, IR_11));
            end
        end
    endtask

    task automatic test_and_not();
        tst_t seq [12] = '{T33, T33, T35, T32, T05, T18, T33, T33, T35, T32, T09, T18};
        Opcode = 4'b0101; IR_5 = 1'b0;
        foreach (seq[i]) begin
            if (i == 6) Opcode = 4'b1001;
            step();
            checks++;
            if (obs !== exp_ctl(seq[i], IR_5, IR_11)) begin
                failures++;
                $display("FAIL and_not[%0d] got=%h exp=%h", i, obs,
                         exp_ctl(seq[i], IR_5, IR_11));
            end
        end
    endtask

    task automatic test_br();
        tst_t seq [13] = '{T33, T33, T35, T32, T00, T22, T18, T33, T33, T35, T32, T00, T18};
        Opcode = 4'b0000; BEN = 1'b1;
        foreach (seq[i]) begin
            if (i == 7) BEN = 1'b0;
            step();
            checks++;
            if (obs !== exp_ctl(seq[i], IR_5, IR_11)) begin
                failures++;
                $display("FAIL br[%0d] got=%h exp=%h", i, obs, exp_ctl(seq[i], IR_5, IR_11));
            end
        end
    endtask

    task automatic test_jmp();
        tst_t seq [6] = '{T33, T33, T35, T32, T12, T18};
        Opcode = 4'b1100;
        foreach (seq[i]) begin
            step();
            checks++;
            if (obs !== exp_ctl(seq[i], IR_5, IR_11)) begin
                failures++;
                $display("FAIL jmp[%0d] got=%h exp=%h", i, obs, exp_ctl(seq[i], IR_5, IR_11));
            end
        end
    endtask

    task automatic test_jsr();
        tst_t seq [14] = '{T33, T33, T35, T32, T04, T21, T18,
                           T33, T33, T35, T32, T04, T21, T18};
        Opcode = 4'b0100; IR_11 = 1'b0;
        foreach (seq[i]) begin
            if (i == 7) IR_11 = 1'b1;
            step();
            checks++;
            if (obs !== exp_ctl(seq[i], IR_5, IR_11)) begin
                failures++;
                $display("FAIL jsr[%0d] ir11=%0b got=%h exp=%h", i, IR_11, obs,
                         exp_ctl(seq[i], IR_5, IR_11));
            end
        end
        IR_11 = 1'b0;
    endtask

    task automatic test_ldr();
        tst_t seq [9] = '{T33, T33, T35, T32, T06, T25, T25, T27, T18};
        Opcode = 4'b0110;
        foreach (seq[i]) begin
            step();
            checks++;
            if (obs !== exp_ctl(seq[i], IR_5, IR_11)) begin
                failures++;
                $display("FAIL ldr[%0d] got=%h exp=%h", i, obs, exp_ctl(seq[i], IR_5, IR_11));
            end
        end
    endtask

    // STR with Run held high throughout: Run must not disturb a running machine.
    task automatic test_str_run_ignored();
        tst_t seq [9] = '{T33, T33, T35, T32, T07, T23, T16, T16, T18};
        Opcode = 4'b0111; Run = 1'b1;
        foreach (seq[i]) begin
            step();
            checks++;
            if (obs !== exp_ctl(seq[i], IR_5, IR_11)) begin
                failures++;
                $display("FAIL str[%0d] got=%h exp=%h", i, obs, exp_ctl(seq[i], IR_5, IR_11));
            end
        end
        Run = 1'b0;
    endtask

    task automatic test_nop();
        tst_t seq [5] = '{T33, T33, T35, T32, T18};
        Opcode = 4'b1111;
        foreach (seq[i]) begin
            step();
            checks++;
            if (obs !== exp_ctl(seq[i], IR_5, IR_11)) begin
                failures++;
                $display("FAIL nop[%0d] got=%h exp=%h", i, obs, exp_ctl(seq[i], IR_5, IR_11));
            end
        end
    endtask

    task automatic test_pause();
        tst_t seq [12] = '{T33, T33, T35, T32, P1, P1, P1, P1, P1, P2, P2, T18};
        Opcode = 4'b1101; Continue = 1'b0;
        foreach (seq[i]) begin
            if (i == 9) Continue = 1'b1;
            if (i == 11) Continue = 1'b0;
            step();
            checks++;
            if (obs !== exp_ctl(seq[i], IR_5, IR_11)) begin
                failures++;
                $display("FAIL pause[%0d] got=%h exp=%h", i, obs, exp_ctl(seq[i], IR_5, IR_11));
            end
        end
    endtask

    task automatic test_reset_mid_read();
        Opcode = 4'b0001;
        step();
        checks++;
        if (obs !== exp_ctl(T33, IR_5, IR_11)) begin
            failures++;
            $display("FAIL mid_read_s33 got=%h exp=%h", obs, exp_ctl(T33, IR_5, IR_11));
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== exp_ctl(HALTED, IR_5, IR_11)) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", obs, exp_ctl(HALTED, IR_5, IR_11));
        end
        #1 Reset_n = 1'b1;
        step();
        checks++;
        if (obs !== exp_ctl(HALTED, IR_5, IR_11)) begin
            failures++;
            $display("FAIL post_reset_halted got=%h exp=%h", obs, exp_ctl(HALTED, IR_5, IR_11));
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_add();
        test_and_not();
        test_br();
        test_jmp();
        test_jsr();
        test_ldr();
        test_str_run_ignored();
        test_nop();
        test_pause();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
